pipelined_logic_tree: RTL
=========================

Name: pipelined_logic_tree

Overview:
- Parametrised, pipelined successor to the team's 8-bit AND-OR reduction tree.
- Computes a leaf bitwise AND of two WIDTH-bit operands, then reduces the result through log2(WIDTH) registered levels to one bit.
- The level operator is selected per transaction by a mode field.
- Streaming valid/ready handshake with full backpressure; sits between operand producers and decision logic in the lab datapath.

Parameters:
- WIDTH, 8, operand width; power of two, >= 2.
- LEVELS, log2(WIDTH), derived localparam, not overridable; number of reduction levels.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands and mode are valid this cycle.
- in_ready, output, 1, block accepts the transaction when in_valid && in_ready.
- x, input, WIDTH, operand A.
- y, input, WIDTH, operand B.
- mode, input, 2, 0=ALT, 1=AND_ALL, 2=OR_ALL, 3=PARITY.
- out_valid, output, 1, z is valid.
- out_ready, input, 1, consumer accepts z when out_valid && out_ready.
- z, output, 1, reduction result.
- out_mode, output, 2, mode that produced z.

Behaviour:
- Pipeline: LEVELS+1 register stages. Stage 0 holds leaf = x & y (WIDTH bits). Stage k (1..LEVELS) holds WIDTH>>k bits.
- Each stage register also carries a valid bit and the 2-bit mode.
- Level k combines bit pairs: out[j] = op_k(in[2j], in[2j+1]).
- op_k by mode:
  - ALT: OR when k odd, AND when k even (WIDTH=8 reproduces the original tree).
  - AND_ALL: AND.
  - OR_ALL: OR.
  - PARITY: XOR.
- z = bit 0 of stage LEVELS; out_valid = valid of stage LEVELS.
- Latency: a transaction accepted at edge n appears with out_valid=1 after edge n+LEVELS, i.e. LEVELS+1 register stages, 4 cycles for WIDTH=8, given no stall.
- Throughput: one transaction per cycle when out_ready is held high.
- Stall rules:
  - advance[LEVELS] = out_ready || !valid[LEVELS].
  - advance[k] = advance[k+1] || !valid[k].
  - in_ready = advance[0].
  - A stage loads from its predecessor only when advance[k]=1; otherwise it holds data, mode and valid.
  - Bubbles collapse: an invalid stage always accepts.
- Handshake:
  - out_valid, z and out_mode are held stable while out_valid && !out_ready.
  - in_ready may depend combinationally on out_ready. No combinational path from in_valid to out_valid.
- Simultaneous events: accept at the input and drain at the output in the same cycle is legal when the pipeline is full, with no loss or duplication.
- Reset (asynchronous, any time including mid-stream):
  - All valid bits, data and mode registers go to 0; out_valid=0, z=0, out_mode=0.
  - In-flight transactions are discarded.
  - in_ready=1 in the first cycle after rst_n deasserts.
- Illegal WIDTH (not a power of two or < 2): elaboration error.

Decomposition:
- Shared package lt_pkg: mode encoding constants (MODE_ALT, MODE_AND_ALL, MODE_OR_ALL, MODE_PARITY) and a clog2 function.
- One natural sub-module, tree_level: generated LEVELS times.
  - Parameters: IN_W, LEVEL_IDX.
  - Function: pairwise reduce plus stage register with valid/mode and hold-on-stall.
- Top level holds the leaf stage and the advance chain.

Test Plan:
- WIDTH=8, out_ready=1, mode=ALT: x=0xFF,y=0x0F -> z=1; x=0x81,y=0xFF -> z=0; x=0x55,y=0xFF -> z=1. Each result appears 4 cycles after acceptance, back-to-back, in order.
- Per-mode check, WIDTH=8: AND_ALL x=0xFF,y=0xFE -> z=0; OR_ALL x=0xF0,y=0x0F -> z=0; PARITY x=0x07,y=0xFF -> z=1; each out_mode matches its input mode.
- Backpressure: stream 6 transactions with out_ready=0 -> in_ready drops after 4 accepted; z/out_mode stable while stalled; releasing out_ready drains all 6 in order with none lost.
- Bubbles: in_valid toggles 1,0,1,0 with out_ready=1 -> out_valid shows the same pattern delayed 4 cycles; in_ready stays 1.
- Reset mid-stream: assert rst_n=0 with 3 transactions in flight -> out_valid=0 and z=0 immediately (asynchronous); no stale output after release; the next transaction has latency 4.
- WIDTH=32, mode=ALT, random x/y against a reference model -> all results match; latency 6.

Source files
------------

// File: rtl/lt_pkg.sv
// Shared definitions for the pipelined logic reduction tree:
// mode encodings and an elaboration-time log2 helper.
package lt_pkg;

    localparam logic [1:0] MODE_ALT     = 2'd0;
    localparam logic [1:0] MODE_AND_ALL = 2'd1;
    localparam logic [1:0] MODE_OR_ALL  = 2'd2;
    localparam logic [1:0] MODE_PARITY  = 2'd3;

    // Smallest n with 2**n >= value; used for the level count.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tree_level.sv
// One reduction level: combines adjacent bit pairs with the mode-selected
// operator and registers the result together with its valid bit and mode.
module tree_level
    import lt_pkg::*;
#(
    parameter int unsigned IN_W      = 2,
    parameter int unsigned LEVEL_IDX = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    output logic [IN_W/2-1:0] out_data,
    output logic [1:0]        out_mode
);

    localparam int unsigned OUT_W     = IN_W / 2;
    localparam bit          ODD_LEVEL = (LEVEL_IDX % 2) == 1;

    function automatic logic pair_op(input logic [1:0] m, input logic a, input logic b);
        case (m)
            MODE_ALT:     pair_op = ODD_LEVEL ? (a | b) : (a & b);
            MODE_AND_ALL: pair_op = a & b;
            MODE_OR_ALL:  pair_op = a | b;
            default:      pair_op = a ^ b;
        endcase
    endfunction

    logic [OUT_W-1:0] reduced;
    logic             valid_q;
    logic [OUT_W-1:0] data_q;
    logic [1:0]       mode_q;

    always_comb begin
        reduced = '0;
        for (int j = 0; j < OUT_W; j++) begin
            reduced[j] = pair_op(in_mode, in_data[2*j], in_data[2*j+1]);
        end
    end

    // Without advance the stage holds everything, which keeps the output stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= '0;
        end else if (advance) begin
            valid_q <= in_valid;
            data_q  <= reduced;
            mode_q  <= in_mode;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_mode  = mode_q;

endmodule

// File: rtl/pipelined_logic_tree.sv
// Pipelined AND-then-reduce tree: leaf AND stage followed by log2(WIDTH)
// registered reduction levels, with valid/ready backpressure.
module pipelined_logic_tree
    import lt_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             z,
    output logic [1:0]       out_mode
);

    localparam int unsigned LEVELS = clog2(WIDTH);
    // All stage data packed end to end: leaf at the bottom, final bit at the top.
    localparam int unsigned BUS_W  = 2 * WIDTH - 1;

    if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $error("pipelined_logic_tree: WIDTH must be a power of two and at least 2");
    end

    logic [BUS_W-1:0]      data_bus;
    logic [LEVELS:0]       stage_valid;
    logic [LEVELS:0]       advance;
    logic [LEVELS:0][1:0]  stage_mode;

    logic [WIDTH-1:0]      leaf_q;
    logic                  leaf_valid_q;
    logic [1:0]            leaf_mode_q;

    // A stage may load if the one after it moves or if it holds only a bubble.
    always_comb begin
        logic carry;
        advance = '0;
        carry   = out_ready;
        for (int k = LEVELS; k >= 0; k--) begin
            carry      = carry | ~stage_valid[k];
            advance[k] = carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leaf_valid_q <= 1'b0;
            leaf_q       <= '0;
            leaf_mode_q  <= '0;
        end else if (advance[0]) begin
            leaf_valid_q <= in_valid;
            leaf_q       <= x & y;
            leaf_mode_q  <= mode;
        end
    end

    assign data_bus[WIDTH-1:0] = leaf_q;
    assign stage_valid[0]      = leaf_valid_q;
    assign stage_mode[0]       = leaf_mode_q;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int unsigned IN_W    = WIDTH >> (k - 1);
        localparam int unsigned IN_OFF  = 2 * WIDTH - 2 * IN_W;
        localparam int unsigned OUT_OFF = IN_OFF + IN_W;

        tree_level #(
            .IN_W      (IN_W),
            .LEVEL_IDX (k)
        ) u_level (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (advance[k]),
            .in_valid  (stage_valid[k-1]),
            .in_data   (data_bus[IN_OFF +: IN_W]),
            .in_mode   (stage_mode[k-1]),
            .out_valid (stage_valid[k]),
            .out_data  (data_bus[OUT_OFF +: IN_W/2]),
            .out_mode  (stage_mode[k])
        );
    end

    assign in_ready  = advance[0];
    assign out_valid = stage_valid[LEVELS];
    assign out_mode  = stage_mode[LEVELS];
    assign z         = data_bus[BUS_W-1];

endmodule
